// File: rtl/serial_adder_fsm_pkg.sv
// serial_adder_fsm shared types: FSM encoding, count sizing
// and the WIDTH/BPC divisibility check.
`ifndef SERIAL_ADDER_FSM_PKG_SV
`define SERIAL_ADDER_FSM_PKG_SV

`define SAF_BPC_DIVIDES(w, b) (((w) % (b)) == 0)

package serial_adder_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/serial_adder_fsm_full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder,
// chained BPC times per slice inside serial_adder_fsm.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: multi-cycle add/sub, BPC bits per clock
// through a ripple slice with a registered inter-slice carry.
module serial_adder_fsm
  import serial_adder_fsm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!`SAF_BPC_DIVIDES(WIDTH, BPC)) begin : g_bad_bpc
    $error("serial_adder_fsm: WIDTH must be a multiple of BPC");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BPC-1:0]   sl_a, sl_b, sl_s;
  logic [BPC:0]     cc;
  logic [WIDTH-1:0] res_next;

  assign sl_a  = a_sh_q[BPC-1:0];
  assign sl_b  = b_sh_q[BPC-1:0] ^ {BPC{sub_q}};
  assign cc[0] = carry_q;

  for (genvar i = 0; i < BPC; i++) begin : g_fa
    full_adder_cell u_fa (
      .a   (sl_a[i]),
      .b   (sl_b[i]),
      .cin (cc[i]),
      .sum (sl_s[i]),
      .cout(cc[i+1])
    );
  end

  // new slice enters at the top; after N slices bit 0 is at the bottom
  assign res_next = WIDTH'({sl_s, res_q} >> BPC);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sub_d   = sub;
          carry_d = sub | cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> BPC;
        b_sh_d  = b_sh_q >> BPC;
        res_d   = res_next;
        carry_d = cc[BPC];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_next;
          cout_d  = cc[BPC];
          ovf_d   = cc[BPC] ^ cc[BPC-1];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: five configurations of serial_adder_fsm
// checked against an arithmetic reference model.
module tb_serial_adder_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sub, cin;
  logic [7:0] a, b;
  logic [4:0] st;

  wire  [4:0] busy_v, done_v, cout_v, ovf_v;
  wire  [7:0] s0, s1;
  wire  [3:0] s2, s3, s4;
  logic [7:0] sum_v [5];

  int vectors = 0;
  int miscompares = 0;
  int wid [5] = '{8, 8, 4, 4, 4};
  int nn  [5] = '{8, 2, 4, 2, 1};

  assign sum_v[0] = s0;
  assign sum_v[1] = s1;
  assign sum_v[2] = {4'b0, s2};
  assign sum_v[3] = {4'b0, s3};
  assign sum_v[4] = {4'b0, s4};

  always #5 clk = ~clk;

  serial_adder_fsm #(.WIDTH(8), .BPC(1)) u_w8b1 (
    .clk(clk), .reset_n(reset_n), .start(st[0]), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]), .sum(s0),
    .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_adder_fsm #(.WIDTH(8), .BPC(4)) u_w8b4 (
    .clk(clk), .reset_n(reset_n), .start(st[1]), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]), .sum(s1),
    .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_adder_fsm #(.WIDTH(4), .BPC(1)) u_w4b1 (
    .clk(clk), .reset_n(reset_n), .start(st[2]), .sub(sub), .cin(cin),
    .a(a[3:0]), .b(b[3:0]), .busy(busy_v[2]), .done(done_v[2]), .sum(s2),
    .cout(cout_v[2]), .ovf(ovf_v[2]));

  serial_adder_fsm #(.WIDTH(4), .BPC(2)) u_w4b2 (
    .clk(clk), .reset_n(reset_n), .start(st[3]), .sub(sub), .cin(cin),
    .a(a[3:0]), .b(b[3:0]), .busy(busy_v[3]), .done(done_v[3]), .sum(s3),
    .cout(cout_v[3]), .ovf(ovf_v[3]));

  serial_adder_fsm #(.WIDTH(4), .BPC(4)) u_w4b4 (
    .clk(clk), .reset_n(reset_n), .start(st[4]), .sub(sub), .cin(cin),
    .a(a[3:0]), .b(b[3:0]), .busy(busy_v[4]), .done(done_v[4]), .sum(s4),
    .cout(cout_v[4]), .ovf(ovf_v[4]));

  // signed/unsigned arithmetic on plain integers
  function automatic void model(input int w, input int ai, input int bi,
                                input bit s, input bit c,
                                output int rs, output bit rc, output bit rv);
    int m, half, sa, sb, sres;
    m    = 1 << w;
    half = m / 2;
    sa   = (ai >= half) ? ai - m : ai;
    sb   = (bi >= half) ? bi - m : bi;
    if (s) begin
      rs   = (ai - bi + m) % m;
      rc   = (ai >= bi);
      sres = sa - sb;
    end else begin
      rs   = (ai + bi + int'(c)) % m;
      rc   = ((ai + bi + int'(c)) >= m);
      sres = sa + sb + int'(c);
    end
    rv = (sres >= half) || (sres < -half);
  endfunction

  // called at a negedge; returns at the negedge after the done cycle
  task automatic do_op(input int k, input logic [7:0] ai, input logic [7:0] bi,
                       input logic s, input logic c,
                       output int lat, output logic [7:0] rs,
                       output logic rc, output logic rv,
                       output int nbusy, output int ndone,
                       output bit early, output bit both, output time t_acc);
    logic [7:0] sv0;
    lat = -1; nbusy = 0; ndone = 0; early = 0; both = 0;
    rs = '0; rc = 1'b0; rv = 1'b0;
    a = ai; b = bi; sub = s; cin = c; st[k] = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1 st[k] = 1'b0;
    sv0 = sum_v[k];
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (busy_v[k]) nbusy++;
      if (busy_v[k] && done_v[k]) both = 1;
      if (done_v[k]) begin
        ndone++;
        if (lat < 0) begin
          lat = j - 1; rs = sum_v[k]; rc = cout_v[k]; rv = ovf_v[k];
        end
      end else if (lat < 0 && sum_v[k] !== sv0) early = 1;
      if (lat >= 0 && j == lat + 2) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; st = '0; sub = 0; cin = 0; a = '0; b = '0;
    #2;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({busy_v[k], done_v[k], sum_v[k], cout_v[k], ovf_v[k]} !== 12'h0) begin
        miscompares++;
        $display("FAIL reset[%0d] busy/done/sum/cout/ovf got %b/%b/%h/%b/%b want all 0",
                 k, busy_v[k], done_v[k], sum_v[k], cout_v[k], ovf_v[k]);
      end
    end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb [5] = '{8'h0F, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [5] = '{8'h4B, 8'h01, 8'h80, 8'hFE, 8'h7F};
    logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       ev [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat, nb, nd; logic [7:0] rs; logic rc, rv; bit early, both; time t;
    for (int i = 0; i < 5; i++) begin
      do_op(0, ta[i], tb[i], ts[i], tc[i], lat, rs, rc, rv, nb, nd, early, both, t);
      vectors++;
      if ({rs, rc, rv} !== {es[i], ec[i], ev[i]}) begin
        miscompares++;
        $display("FAIL directed[%0d] sum/cout/ovf got %h/%b/%b want %h/%b/%b",
                 i, rs, rc, rv, es[i], ec[i], ev[i]);
      end
      vectors++;
      if (lat != 8 || nb != 8 || nd != 1 || both || early) begin
        miscompares++;
        $display("FAIL directed_timing[%0d] lat/busy/dones/overlap/early got %0d/%0d/%0d/%0d/%0d want 8/8/1/0/0",
                 i, lat, nb, nd, both, early);
      end
    end
  endtask

  task automatic test_ignore_and_abort();
    int lat, nb, nd; logic [7:0] rs, got; logic rc, rv; bit early, both; time t;
    a = 8'h10; b = 8'h20; sub = 0; cin = 0; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    nd = 0; lat = -1; got = '0;
    for (int j = 4; j <= 24; j++) begin
      @(negedge clk);
      if (done_v[0]) begin
        nd++;
        if (lat < 0) begin lat = j - 1; got = sum_v[0]; end
      end
    end
    vectors++;
    if (got !== 8'h30 || nd != 1 || lat != 8) begin
      miscompares++;
      $display("FAIL ignore_start sum/dones/lat got %h/%0d/%0d want 30/1/8", got, nd, lat);
    end
    a = 8'h55; b = 8'h11; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy_v[0], done_v[0], sum_v[0], cout_v[0], ovf_v[0]} !== 12'h0) begin
      miscompares++;
      $display("FAIL abort busy/done/sum/cout/ovf got %b/%b/%h/%b/%b want all 0",
               busy_v[0], done_v[0], sum_v[0], cout_v[0], ovf_v[0]);
    end
    @(negedge clk) reset_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) nd++;
    end
    vectors++;
    if (nd != 0) begin
      miscompares++;
      $display("FAIL abort_quiet busy/done cycles got %0d want 0", nd);
    end
    do_op(0, 8'h21, 8'h43, 1'b0, 1'b1, lat, rs, rc, rv, nb, nd, early, both, t);
    vectors++;
    if ({rs, rc, rv} !== {8'h65, 1'b0, 1'b0} || lat != 8 || nd != 1) begin
      miscompares++;
      $display("FAIL after_abort sum/cout/ovf/lat/dones got %h/%b/%b/%0d/%0d want 65/0/0/8/1",
               rs, rc, rv, lat, nd);
    end
  endtask

  task automatic test_bpc4();
    int lat, nb, nd, lat2; logic [7:0] rs; logic rc, rv; bit early, both; time t1, t2;
    do_op(1, 8'h9A, 8'h77, 1'b0, 1'b0, lat, rs, rc, rv, nb, nd, early, both, t1);
    vectors++;
    if ({rs, rc, rv} !== {8'h11, 1'b1, 1'b0} || lat != 2 || nd != 1 || nb != 2) begin
      miscompares++;
      $display("FAIL bpc4 sum/cout/ovf/lat/dones/busy got %h/%b/%b/%0d/%0d/%0d want 11/1/0/2/1/2",
               rs, rc, rv, lat, nd, nb);
    end
    do_op(1, 8'h01, 8'h02, 1'b1, 1'b0, lat2, rs, rc, rv, nb, nd, early, both, t2);
    do_op(1, 8'h40, 8'h40, 1'b0, 1'b0, lat2, rs, rc, rv, nb, nd, early, both, t1);
    vectors++;
    if (t1 - t2 != 40 || {rs, rc, rv} !== {8'h80, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL back_to_back spacing/sum/cout/ovf got %0t/%h/%b/%b want 40/80/0/1",
               t1 - t2, rs, rc, rv);
    end
  endtask

  task automatic test_random();
    int lat, nb, nd, es; logic [7:0] rs, ra, rb; logic rc, rv, rsub, rcin;
    bit ec, ev, early, both; time t;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        rsub = 1'($urandom); rcin = 1'($urandom);
        model(8, int'(ra), int'(rb), rsub, rcin, es, ec, ev);
        do_op(k, ra, rb, rsub, rcin, lat, rs, rc, rv, nb, nd, early, both, t);
        vectors++;
        if ({rs, rc, rv} !== {8'(es), ec, ev} || lat != nn[k] || nd != 1 || both || early) begin
          miscompares++;
          $display("FAIL random[%0d] %h%s%h cin=%b sum/cout/ovf/lat got %h/%b/%b/%0d want %h/%b/%b/%0d",
                   k, ra, rsub ? "-" : "+", rb, rcin, rs, rc, rv, lat, 8'(es), ec, ev, nn[k]);
        end
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    int lat, nb, nd, es; logic [7:0] rs, ra, rb; logic rc, rv, rsub, rcin;
    bit ec, ev, early, both; time t;
    for (int k = 2; k < 5; k++) begin
      for (int v = 0; v < 1024; v++) begin
        ra = {4'b0, v[3:0]}; rb = {4'b0, v[7:4]};
        rcin = v[8]; rsub = v[9];
        model(wid[k], int'(ra), int'(rb), rsub, rcin, es, ec, ev);
        do_op(k, ra, rb, rsub, rcin, lat, rs, rc, rv, nb, nd, early, both, t);
        vectors++;
        if ({rs, rc, rv} !== {8'(es), ec, ev}) begin
          miscompares++;
          $display("FAIL exh[%0d] %h%s%h cin=%b sum/cout/ovf got %h/%b/%b want %h/%b/%b",
                   k, ra, rsub ? "-" : "+", rb, rcin, rs, rc, rv, 8'(es), ec, ev);
        end
        vectors++;
        if (lat != nn[k] || nb != nn[k] || nd != 1 || both) begin
          miscompares++;
          $display("FAIL exh_timing[%0d] v=%0d lat/busy/dones got %0d/%0d/%0d want %0d/%0d/1",
                   k, v, lat, nb, nd, nn[k], nn[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_and_abort();
    test_bpc4();
    test_random();
    test_exhaustive_w4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
